// File: rtl/ff4_reader.sv
// Samples an enabled upstream register into a FWFT buffer, optionally keeping only changed values.
// Latency: one edge from qualifying sample to dout; a full buffer drops new samples and sets overflow.
module ff4_reader #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [WIDTH-1:0]         q_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [WIDTH-1:0]  last;
  logic              seen;
  logic              qualify;
  logic              push;
  logic              pop;

  // The first sample after reset always qualifies, even if it matches the cleared last value.
  assign qualify = en & ((CHANGE_ONLY == 0) | ~seen | (q_in != last));
  assign pop     = rd_en & valid;
  assign push    = qualify & (~full | pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_EMPTY;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      valid    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
      last     <= '0;
      seen     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (en) begin
        last <= q_in;
        seen <= 1'b1;
      end
      if (push) begin
        mem[wptr] <= q_in;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (qualify & full & ~pop) begin
        overflow <= 1'b1;
      end
      if (push & ~pop) begin
        count <= count + 1'b1;
      end else if (pop & ~push) begin
        count <= count - 1'b1;
      end

      // Flags are registered alongside count so they never glitch on input changes.
      case (state)
        S_EMPTY: begin
          if (push) begin
            state <= S_PARTIAL;
            valid <= 1'b1;
          end
        end
        S_PARTIAL: begin
          if (push & ~pop & (count == CNT_LAST)) begin
            state <= S_FULL;
            full  <= 1'b1;
          end else if (pop & ~push & (count == CNT_ONE)) begin
            state <= S_EMPTY;
            valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (pop & ~push) begin
            state <= S_PARTIAL;
            full  <= 1'b0;
          end
        end
        default: begin
          state <= S_EMPTY;
          valid <= 1'b0;
          full  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff4_reader.sv
// Directed bench for ff4_reader: change filtering, full/overflow, simultaneous push/pop, async reset.
module tb_ff4_reader;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] q_in;
  logic       rd_en;
  logic [3:0] dout;
  logic       valid;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  ff4_reader #(.WIDTH(4), .DEPTH(4), .CHANGE_ONLY(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .q_in     (q_in),
    .rd_en    (rd_en),
    .dout     (dout),
    .valid    (valid),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    q_in  = 4'b0000;
    rd_en = 1'b0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b1;
    tick();
    chk("idle_count", count, 0);

    // First enabled sample lands on dout after one edge
    en = 1'b1; q_in = 4'b1100;
    tick();
    chk("first_valid", valid, 1);
    chk("first_dout", dout, 4'b1100);
    chk("first_count", count, 1);
    en = 1'b0; rd_en = 1'b1;
    tick();
    chk("first_pop_count", count, 0);
    chk("first_pop_valid", valid, 0);
    rd_en = 1'b0;

    // Held value is stored once, a new value once more
    en = 1'b1; q_in = 4'b0110;
    tick(); tick(); tick();
    chk("hold_count", count, 1);
    q_in = 4'b1111;
    tick();
    chk("change_count", count, 2);
    en = 1'b0;
    chk("change_head0", dout, 4'b0110);
    rd_en = 1'b1;
    tick();
    chk("change_head1", dout, 4'b1111);
    chk("change_pop_count", count, 1);
    tick();
    chk("change_empty_count", count, 0);
    chk("change_empty_valid", valid, 0);
    tick();
    chk("pop_when_empty_count", count, 0);
    rd_en = 1'b0;

    // en=0 must ignore q_in and leave last alone (1111 re-presented must not qualify)
    for (int i = 0; i < 4; i++) begin
      q_in = (i % 2 == 0) ? 4'b0011 : 4'b1101;
      tick();
    end
    chk("disabled_count", count, 0);
    en = 1'b1; q_in = 4'b1111;
    tick();
    chk("last_kept_count", count, 0);

    // Fill to full, then overflow
    for (int i = 1; i <= 4; i++) begin
      q_in = 4'(i);
      tick();
    end
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    chk("fill_overflow", overflow, 0);
    q_in = 4'b0101;
    tick();
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    en = 1'b0;
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", dout, 32'(i));
      tick();
    end
    chk("ovf_drain_valid", valid, 0);
    chk("ovf_sticky", overflow, 1);
    rd_en = 1'b0;

    // Reset clears overflow; then push and pop together while full
    reset = 1'b0;
    #1;
    chk("rst2_overflow", overflow, 0);
    reset = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      q_in = 4'(i);
      tick();
    end
    chk("full2_full", full, 1);
    q_in = 4'b0110; rd_en = 1'b1;
    tick();
    chk("pushpop_count", count, 4);
    chk("pushpop_full", full, 1);
    chk("pushpop_overflow", overflow, 0);
    chk("pushpop_head", dout, 4'b0010);
    en = 1'b0;
    tick();
    chk("pushpop_d3", dout, 4'b0011);
    tick();
    chk("pushpop_d4", dout, 4'b0100);
    tick();
    chk("pushpop_last", dout, 4'b0110);
    tick();
    chk("pushpop_empty", valid, 0);
    rd_en = 1'b0;

    // Build count=3 with overflow, then reset between edges
    en = 1'b1;
    q_in = 4'b1010; tick();
    q_in = 4'b1011; tick();
    q_in = 4'b1100; tick();
    q_in = 4'b1101; tick();
    q_in = 4'b1110; tick();
    chk("pre_rst_overflow", overflow, 1);
    en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pre_rst_count", count, 3);
    #1;
    reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", valid, 0);
    chk("async_overflow", overflow, 0);
    chk("async_dout", dout, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("release_count", count, 0);
    en = 1'b1; q_in = 4'b1110;
    tick();
    chk("post_rst_count", count, 1);
    chk("post_rst_dout", dout, 4'b1110);
    en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ff4_reader.md
FF4_READER -- requirements
Module: ff4_reader

Interface
REQ-001 Parameter WIDTH, default 4, bit width of the sampled register value and of dout.
REQ-002 Parameter DEPTH, default 4, number of buffer entries; power of two, at least 2.
REQ-003 Parameter CHANGE_ONLY, default 1; 1 pushes only changed values, 0 pushes every enabled sample.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 en  input  1  sample enable; q_in is examined only on edges where en=1.
REQ-007 q_in  input  WIDTH  Q output of the upstream enabled D register being read.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 dout  output  WIDTH  oldest buffered value (first-word-fall-through).
REQ-010 valid  output  1  1 when at least one entry is buffered; dout is meaningful only then.
REQ-011 full  output  1  1 when DEPTH entries are buffered.
REQ-012 count  output  log2(DEPTH)+1  number of buffered entries, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a qualified sample was dropped.

Function
REQ-014 The block SHALL hold internal register last (WIDTH) and flag seen (1) recording the most recent sampled q_in.
REQ-015 A sample qualifies on an edge with en=1 when CHANGE_ONLY=0, or seen=0, or q_in != last.
REQ-016 On every edge with en=1, last SHALL load q_in and seen SHALL be set to 1, whether or not the sample qualifies or is stored.
REQ-017 pop = rd_en & valid; rd_en while valid=0 SHALL be ignored with no state change.
REQ-018 push = qualify & (~full | pop); a qualifying sample while full with no pop SHALL be dropped and overflow set to 1.
REQ-019 push and pop on the same edge SHALL both occur; count SHALL be unchanged, including when full.
REQ-020 Write and read pointers SHALL wrap modulo DEPTH.
REQ-021 count SHALL be +1 on push only, -1 on pop only, unchanged otherwise.
REQ-022 Occupancy state machine: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH). valid=1 outside EMPTY; full=1 only in FULL.
REQ-023 EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop at count=DEPTH-1; FULL->PARTIAL on pop without push; PARTIAL->EMPTY on pop without push at count=1; all other cases stay.
REQ-024 Latency: a value pushed at edge k SHALL appear on dout, with valid=1, after edge k when the buffer was empty before that edge.
REQ-025 dout SHALL present the head entry combinationally from the read pointer and SHALL advance to the next entry after each pop.
REQ-026 overflow SHALL remain 1 until reset; no other input clears it.

Reset
REQ-027 With reset=0, all state SHALL clear asynchronously, without waiting for clk: pointers 0, count 0, valid 0, full 0, overflow 0, seen 0, last 0, dout 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; after release, the first enabled sample SHALL qualify regardless of value.
REQ-029 When reset releases, the first state change SHALL occur on the next rising clk edge.

Verification
REQ-030 After reset, en=1 with q_in=1100 -> valid=1, dout=1100, count=1 after one edge.
REQ-031 With CHANGE_ONLY=1, en=1 and q_in held at 0110 for 3 edges -> count=1; q_in then 1111 -> count=2; rd_en pops -> dout=0110 then 1111.
REQ-032 With en=0 and q_in toggling 0011/1101 -> count stays 0, last unchanged.
REQ-033 Push values 0001..0100 to full, then push 0101 with rd_en=0 -> count=4, overflow=1, popped order 0001,0010,0011,0100.
REQ-034 When full, push 0110 and pop on the same edge -> count stays 4, full=1, overflow stays 0, last popped entry is 0110.
REQ-035 reset pulsed low between clock edges with count=3 and overflow=1 -> count=0, valid=0, overflow=0 immediately; q_in equal to the old last value is stored on the next enabled edge.
